rabbit_spawner: RTL and testbench

RABBIT_SPAWNER -- requirements
Module: rabbit_spawner

---
 rtl/rabbit_spawner.sv | 138 +++++++++++++
 tb/tb_rabbit_spawner.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/rabbit_spawner.sv
// rtl/rabbit_spawner.sv - LFSR-driven rabbit placement FSM for the snake game
//
// Places a single rabbit on an 8-LED strip, away from the snake head and
// never twice in a row at the same position. After the score stage reports
// an eat, no rabbit is shown for COOLDOWN cycles. If LIFETIME is nonzero,
// an uneaten rabbit moves to a new position after LIFETIME cycles.
//
// Ports:
//   clk        - sole clock, rising edge
//   rst_n      - asynchronous active-low reset
//   enable     - game running; low forces IDLE on the next edge
//   snake_led  - one-hot snake head position (0 = none)
//   eaten      - asynchronous level from the score stage
//   rabbit_led - registered one-hot rabbit position (0 = no rabbit)
//   spawned    - one-cycle pulse while a newly placed rabbit first shows
//   busy       - high while picking a position or cooling down
module rabbit_spawner #(
  parameter logic [7:0]  SEED     = 8'hA5,
  parameter int unsigned COOLDOWN = 16,
  parameter int unsigned LIFETIME = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] snake_led,
  input  logic       eaten,
  output logic [7:0] rabbit_led,
  output logic       spawned,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_PICK, S_SHOW, S_COOL} state_t;

  localparam logic [15:0] LIFE_INIT = 16'(LIFETIME);
  localparam logic [7:0]  COOL_INIT = 8'(COOLDOWN - 1);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_lfsr;
  logic [7:0]  r_rabbit_led, w_rabbit_nxt;
  logic [7:0]  r_last_led, w_last_nxt;
  logic [15:0] r_life, w_life_nxt;
  logic [7:0]  r_cool, w_cool_nxt;
  logic        r_spawned, w_spawned_nxt;
  logic        r_sync1, r_sync2, r_sync3;
  logic        w_fb;
  logic        w_eat_pulse;
  logic [7:0]  w_candidate;

  // x^8 + x^6 + x^5 + x^4 + 1: maximal length, so a nonzero seed never hits 0
  assign w_fb        = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_candidate = 8'd1 << r_lfsr[2:0];

  // sync1/sync2 resynchronise eaten; sync3 only delays for the edge detect,
  // so a held eaten level registers as a single eat
  assign w_eat_pulse = r_sync2 & ~r_sync3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_lfsr       <= SEED;
      r_rabbit_led <= 8'd0;
      r_last_led   <= 8'd0;
      r_life       <= 16'd0;
      r_cool       <= 8'd0;
      r_spawned    <= 1'b0;
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_sync3      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_lfsr       <= {r_lfsr[6:0], w_fb};
      r_rabbit_led <= w_rabbit_nxt;
      r_last_led   <= w_last_nxt;
      r_life       <= w_life_nxt;
      r_cool       <= w_cool_nxt;
      r_spawned    <= w_spawned_nxt;
      r_sync1      <= eaten;
      r_sync2      <= r_sync1;
      r_sync3      <= r_sync2;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_rabbit_nxt  = r_rabbit_led;
    w_last_nxt    = r_last_led;
    w_life_nxt    = r_life;
    w_cool_nxt    = r_cool;
    w_spawned_nxt = 1'b0;

    if (!enable) begin
      // last_led is deliberately kept so re-enable cannot respawn in place
      w_state_nxt  = S_IDLE;
      w_rabbit_nxt = 8'd0;
    end else begin
      unique case (r_state)
        S_IDLE: w_state_nxt = S_PICK;
        S_PICK: begin
          if ((w_candidate != snake_led) && (w_candidate != r_last_led)) begin
            w_rabbit_nxt  = w_candidate;
            w_last_nxt    = w_candidate;
            w_spawned_nxt = 1'b1;
            w_life_nxt    = LIFE_INIT;
            w_state_nxt   = S_SHOW;
          end
        end
        S_SHOW: begin
          // an eat wins over a simultaneous lifetime expiry
          if (w_eat_pulse) begin
            w_rabbit_nxt = 8'd0;
            w_cool_nxt   = COOL_INIT;
            w_state_nxt  = S_COOL;
          end else if (LIFETIME != 0) begin
            w_life_nxt = r_life - 16'd1;
            if (r_life == 16'd1) begin
              w_rabbit_nxt = 8'd0;
              w_state_nxt  = S_PICK;
            end
          end
        end
        S_COOL: begin
          // counter runs COOLDOWN-1 .. 0, giving COOLDOWN cycles in COOL
          if (r_cool == 8'd0) begin
            w_state_nxt = S_PICK;
          end else begin
            w_cool_nxt = r_cool - 8'd1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign rabbit_led = r_rabbit_led;
  assign spawned    = r_spawned;
  assign busy       = (r_state == S_PICK) || (r_state == S_COOL);

endmodule

// File: tb/tb_rabbit_spawner.sv
// tb/tb_rabbit_spawner.sv - randomized self-checking bench for rabbit_spawner
module tb_rabbit_spawner;

  localparam logic [7:0] SEED = 8'hA5;
  localparam int LIFE [2] = '{0, 4};
  localparam int CDN  [2] = '{16, 3};

  localparam int M_IDLE = 0;
  localparam int M_PICK = 1;
  localparam int M_SHOW = 2;
  localparam int M_COOL = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] snake_led = 8'd0;
  logic       eaten = 1'b0;

  logic [7:0] rabbit_led0, rabbit_led1;
  logic       spawned0, spawned1;
  logic       busy0, busy1;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state, one slot per DUT instance
  int         m_mode   [2] = '{M_IDLE, M_IDLE};
  int         m_left   [2] = '{0, 0};
  logic [7:0] m_rabbit [2] = '{8'd0, 8'd0};
  logic [7:0] m_last   [2] = '{8'd0, 8'd0};
  logic       m_spawned[2] = '{1'b0, 1'b0};
  logic [7:0] m_lfsr = SEED;
  logic       h0 = 1'b0, h1 = 1'b0, h2 = 1'b0;

  always #5 clk = ~clk;

  rabbit_spawner u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .snake_led(snake_led),
    .eaten(eaten), .rabbit_led(rabbit_led0), .spawned(spawned0), .busy(busy0)
  );

  rabbit_spawner #(.SEED(SEED), .COOLDOWN(3), .LIFETIME(4)) u_dut_life (
    .clk(clk), .rst_n(rst_n), .enable(enable), .snake_led(snake_led),
    .eaten(eaten), .rabbit_led(rabbit_led1), .spawned(spawned1), .busy(busy1)
  );

  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".rabbit0"},  rabbit_led0, m_rabbit[0]);
    check_eq({tag, ".spawned0"}, {7'd0, spawned0}, {7'd0, m_spawned[0]});
    check_eq({tag, ".busy0"},    {7'd0, busy0},
             {7'd0, (m_mode[0] == M_PICK) || (m_mode[0] == M_COOL)});
    check_eq({tag, ".onehot0"},  {7'd0, $onehot0(rabbit_led0)}, 8'd1);
    check_eq({tag, ".rabbit1"},  rabbit_led1, m_rabbit[1]);
    check_eq({tag, ".spawned1"}, {7'd0, spawned1}, {7'd0, m_spawned[1]});
    check_eq({tag, ".busy1"},    {7'd0, busy1},
             {7'd0, (m_mode[1] == M_PICK) || (m_mode[1] == M_COOL)});
    check_eq({tag, ".onehot1"},  {7'd0, $onehot0(rabbit_led1)}, 8'd1);
  endtask

  // Behavioural model: game rules per edge, with eats seen two edges after
  // the eaten level was first sampled high.
  initial begin
    logic       eat_now;
    logic [7:0] cand;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < 2; i++) begin
          m_mode[i]    = M_IDLE;
          m_left[i]    = 0;
          m_rabbit[i]  = 8'd0;
          m_last[i]    = 8'd0;
          m_spawned[i] = 1'b0;
        end
        m_lfsr = SEED;
        h0 = 1'b0; h1 = 1'b0; h2 = 1'b0;
      end else begin
        eat_now = h1 & ~h2;
        cand    = 8'd1 << m_lfsr[2:0];
        for (int i = 0; i < 2; i++) begin
          m_spawned[i] = 1'b0;
          if (!enable) begin
            m_mode[i]   = M_IDLE;
            m_rabbit[i] = 8'd0;
          end else begin
            case (m_mode[i])
              M_IDLE: m_mode[i] = M_PICK;
              M_PICK: begin
                if (cand != snake_led && cand != m_last[i]) begin
                  m_rabbit[i]  = cand;
                  m_last[i]    = cand;
                  m_spawned[i] = 1'b1;
                  m_mode[i]    = M_SHOW;
                  m_left[i]    = LIFE[i];
                end
              end
              M_SHOW: begin
                if (eat_now) begin
                  m_rabbit[i] = 8'd0;
                  m_mode[i]   = M_COOL;
                  m_left[i]   = CDN[i];
                end else if (LIFE[i] != 0) begin
                  m_left[i]--;
                  if (m_left[i] == 0) begin
                    m_rabbit[i] = 8'd0;
                    m_mode[i]   = M_PICK;
                  end
                end
              end
              M_COOL: begin
                m_left[i]--;
                if (m_left[i] == 0) m_mode[i] = M_PICK;
              end
              default: m_mode[i] = M_IDLE;
            endcase
          end
        end
        m_lfsr = lfsr_next(m_lfsr);
        h2 = h1; h1 = h0; h0 = eaten;
      end
    end
  end

  initial begin
    int dis_cnt = 0;
    int resets_done = 0;
    int cool_drops = 0;
    int r;

    repeat (3) @(negedge clk);
    check_all("reset");
    check_eq("reset.rabbit_const", rabbit_led0, 8'd0);
    rst_n  = 1'b1;
    enable = 1'b1;

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      check_all("run");

      // enable drops: random, plus a 10-cycle drop during cooldown
      if (dis_cnt > 0) begin
        dis_cnt--;
        enable = (dis_cnt == 0);
      end else if (m_mode[0] == M_COOL && cool_drops < 3 && c > 200) begin
        cool_drops++;
        enable  = 1'b0;
        dis_cnt = 10;
      end else if ($urandom_range(0, 199) == 0) begin
        enable  = 1'b0;
        dis_cnt = $urandom_range(1, 12);
      end

      if ($urandom_range(0, 4) == 0) eaten = ~eaten;

      r = $urandom_range(0, 3);
      if (r == 0)      snake_led = 8'd0;
      else if (r == 1) snake_led = 8'd1 << m_lfsr[2:0];
      else             snake_led = 8'd1 << $urandom_range(0, 7);

      // asynchronous reset between edges while a rabbit is showing
      if (m_mode[0] == M_SHOW && c > 100 &&
          ((resets_done == 0 && c > 1500) || $urandom_range(0, 299) == 0)) begin
        resets_done++;
        #2 rst_n = 1'b0;
        #1;
        check_all("async_rst");
        check_eq("async_rst.rabbit_const",  rabbit_led0, 8'd0);
        check_eq("async_rst.spawned_const", {7'd0, spawned0}, 8'd0);
        check_eq("async_rst.busy_const",    {7'd0, busy1}, 8'd0);
        @(negedge clk);
        check_all("in_rst");
        rst_n = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
